// File: rtl/noc_pkg.sv
// noc_pkg: constants and types shared by the mesh network interface logic.
//   PACKET_WIDTH      packet and processor data bus width
//   NIC_ADDR_*        processor register map of the NIC
//   PKT_VC_BIT        packet bit that selects the virtual channel
//   nic_state_e       injection state machine encoding
package noc_pkg;
    localparam int PACKET_WIDTH = 64;

    localparam logic [1:0] NIC_ADDR_IN_BUF   = 2'b00;
    localparam logic [1:0] NIC_ADDR_IN_STAT  = 2'b01;
    localparam logic [1:0] NIC_ADDR_OUT_BUF  = 2'b10;
    localparam logic [1:0] NIC_ADDR_OUT_STAT = 2'b11;

    localparam int PKT_VC_BIT = PACKET_WIDTH - 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } nic_state_e;
endpackage

// File: rtl/nic_chan_buf.sv
// nic_chan_buf: single-entry channel buffer with a full flag.
//   clk, reset   clock and asynchronous active-low reset
//   load, d      capture d when the buffer is empty
//   clear        empty the buffer (load into an empty buffer wins)
//   full, data   status flag and held word
module nic_chan_buf
    import noc_pkg::*;
#(
    parameter int W = PACKET_WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         full,
    output logic [W-1:0] data
);
    logic         full_q;
    logic [W-1:0] data_q;

    // A load while full is dropped: the held word is never overwritten.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (load && !full_q) begin
            full_q <= 1'b1;
            data_q <= d;
        end else if (clear) begin
            full_q <= 1'b0;
        end
    end

    assign full = full_q;
    assign data = data_q;
endmodule

// File: rtl/noc_nic.sv
// noc_nic: processor-side network interface for one router PE port.
//   clk, reset              clock, asynchronous active-low reset
//   addr, d_in, d_out       processor register select, write data, read data
//   nic_en, nic_en_wr       access strobe, write(1)/read(0)
//   net_si, net_ri, net_di  ejection channel from the router
//   net_so, net_ro, net_do  injection channel into the router
//   net_polarity            router virtual-channel phase
module noc_nic
    import noc_pkg::*;
#(
    parameter int PACKET_WIDTH = noc_pkg::PACKET_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              addr,
    input  logic [PACKET_WIDTH-1:0] d_in,
    output logic [PACKET_WIDTH-1:0] d_out,
    input  logic                    nic_en,
    input  logic                    nic_en_wr,
    input  logic                    net_si,
    output logic                    net_ri,
    input  logic [PACKET_WIDTH-1:0] net_di,
    output logic                    net_so,
    input  logic                    net_ro,
    output logic [PACKET_WIDTH-1:0] net_do,
    input  logic                    net_polarity
);
    localparam int VC_BIT = PACKET_WIDTH - 1;

    logic                    in_full, out_full;
    logic [PACKET_WIDTH-1:0] in_buf, out_buf;
    logic                    proc_rd_in, proc_wr_out, drain;

    nic_state_e              state_q, state_d;
    logic                    net_so_q, net_so_d;
    logic [PACKET_WIDTH-1:0] net_do_q, net_do_d;

    assign proc_rd_in  = nic_en && !nic_en_wr && (addr == NIC_ADDR_IN_BUF);
    assign proc_wr_out = nic_en &&  nic_en_wr && (addr == NIC_ADDR_OUT_BUF);

    nic_chan_buf #(.W(PACKET_WIDTH)) u_in_buf (
        .clk   (clk),
        .reset (reset),
        .load  (net_si),
        .clear (proc_rd_in),
        .d     (net_di),
        .full  (in_full),
        .data  (in_buf)
    );

    nic_chan_buf #(.W(PACKET_WIDTH)) u_out_buf (
        .clk   (clk),
        .reset (reset),
        .load  (proc_wr_out),
        .clear (drain),
        .d     (d_in),
        .full  (out_full),
        .data  (out_buf)
    );

    assign net_ri = !in_full;

    always_comb begin
        d_out = '0;
        case (addr)
            NIC_ADDR_IN_BUF:   d_out = in_buf;
            NIC_ADDR_IN_STAT:  d_out = PACKET_WIDTH'(in_full);
            NIC_ADDR_OUT_STAT: d_out = PACKET_WIDTH'(out_full);
            default:           d_out = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            net_so_q <= 1'b0;
            net_do_q <= '0;
        end else begin
            state_q  <= state_d;
            net_so_q <= net_so_d;
            net_do_q <= net_do_d;
        end
    end

    // A packet only leaves when its VC bit matches the router phase; the
    // SEND state lasts one cycle so net_so is always a single-cycle pulse.
    always_comb begin
        state_d  = state_q;
        net_so_d = 1'b0;
        net_do_d = net_do_q;
        drain    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (out_full && net_ro && (out_buf[VC_BIT] == net_polarity)) begin
                    state_d  = ST_SEND;
                    net_so_d = 1'b1;
                    net_do_d = out_buf;
                    drain    = 1'b1;
                end
            end
            ST_SEND: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign net_so = net_so_q;
    assign net_do = net_do_q;
endmodule

// File: tb/tb_noc_nic.sv
module tb_noc_nic;
    localparam int PW = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [1:0]    addr = 2'b00;
    logic [PW-1:0] d_in = '0;
    logic [PW-1:0] d_out;
    logic          nic_en = 1'b0;
    logic          nic_en_wr = 1'b0;
    logic          net_si = 1'b0;
    logic          net_ri;
    logic [PW-1:0] net_di = '0;
    logic          net_so;
    logic          net_ro = 1'b0;
    logic [PW-1:0] net_do;
    logic          net_polarity = 1'b0;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;

    // Reference model: what software-visible state the NIC should hold.
    logic          m_in_full, m_out_full, m_so;
    logic [PW-1:0] m_in_buf, m_out_buf, m_do;

    noc_nic dut (
        .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
        .nic_en(nic_en), .nic_en_wr(nic_en_wr),
        .net_si(net_si), .net_ri(net_ri), .net_di(net_di),
        .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
        .net_polarity(net_polarity)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_in_full = 0; m_out_full = 0; m_so = 0;
        m_in_buf = '0; m_out_buf = '0; m_do = '0;
    endtask

    function automatic logic [PW-1:0] model_dout(input logic [1:0] a);
        case (a)
            2'b00:   return m_in_buf;
            2'b01:   return PW'(m_in_full);
            2'b11:   return PW'(m_out_full);
            default: return '0;
        endcase
    endfunction

    task automatic peek(input logic [1:0] a);
        addr = a;
        #1;
        chk($sformatf("d_out[%0d]", a), d_out, model_dout(a));
    endtask

    // One clock edge: advance the model with the inputs present at the edge,
    // then compare every output a little after the edge.
    task automatic cycle();
        logic rd, wrt, fire;
        @(posedge clk);
        cyc++;
        rd   = nic_en && !nic_en_wr && (addr == 2'b00);
        wrt  = nic_en &&  nic_en_wr && (addr == 2'b10);
        fire = !m_so && m_out_full && net_ro && (m_out_buf[PW-1] == net_polarity);
        if (net_si && !m_in_full) begin
            m_in_buf  = net_di;
            m_in_full = 1;
        end else if (rd) begin
            m_in_full = 0;
        end
        if (fire) begin
            m_do       = m_out_buf;
            m_out_full = 0;
        end else if (wrt && !m_out_full) begin
            m_out_buf  = d_in;
            m_out_full = 1;
        end
        m_so = fire;
        #1;
        chk("net_ri", PW'(net_ri), PW'(!m_in_full));
        chk("net_so", PW'(net_so), PW'(m_so));
        chk("net_do", net_do, m_do);
        chk("d_out",  d_out, model_dout(addr));
        $display("cyc %0d en=%b wr=%b a=%0d si=%b ro=%b pol=%b -> so=%b ri=%b do=%h",
                 cyc, nic_en, nic_en_wr, addr, net_si, net_ro, net_polarity,
                 net_so, net_ri, net_do);
    endtask

    task automatic proc_write(input logic [PW-1:0] v);
        nic_en = 1; nic_en_wr = 1; addr = 2'b10; d_in = v;
        cycle();
        nic_en = 0; nic_en_wr = 0;
    endtask

    initial begin
        model_reset();
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_net_ri", PW'(net_ri), PW'(1));
        chk("rst_net_so", PW'(net_so), PW'(0));
        chk("rst_net_do", net_do, '0);
        peek(2'b01);
        peek(2'b11);
        peek(2'b00);
        @(negedge clk) reset = 1;

        // Injection with phase already matching
        net_ro = 1; net_polarity = 1;
        proc_write(64'h8000_0000_0000_00A5);
        peek(2'b11);
        chk("inj_pending", d_out, 64'h1);
        cycle();
        chk("inj_pulse", PW'(net_so), PW'(1));
        chk("inj_data", net_do, 64'h8000_0000_0000_00A5);
        peek(2'b11);
        chk("inj_stat_after", d_out, 64'h0);
        cycle();
        chk("inj_one_cycle", PW'(net_so), PW'(0));

        // Phase stall, second write dropped
        net_polarity = 0;
        proc_write(64'h8000_0000_0000_0001);
        repeat (3) cycle();
        chk("stall_no_so", PW'(net_so), PW'(0));
        proc_write(64'h8000_0000_0000_0002);
        net_polarity = 1;
        cycle();
        chk("stall_pulse", PW'(net_so), PW'(1));
        chk("stall_first_pkt", net_do, 64'h8000_0000_0000_0001);
        repeat (3) cycle();
        chk("stall_single_pulse", PW'(net_so), PW'(0));
        chk("stall_do_held", net_do, 64'h8000_0000_0000_0001);

        // Ejection, overflow, read-clear
        net_si = 1; net_di = 64'h0123_4567_89AB_CDEF;
        cycle();
        net_si = 0;
        chk("ej_ri_low", PW'(net_ri), PW'(0));
        peek(2'b01);
        chk("ej_stat", d_out, 64'h1);
        net_si = 1; net_di = 64'h0000_0000_0000_DEAD;
        cycle();
        net_si = 0;
        peek(2'b00);
        chk("ovf_keep", d_out, 64'h0123_4567_89AB_CDEF);
        nic_en = 1; nic_en_wr = 0; addr = 2'b00;
        cycle();
        nic_en = 0;
        chk("rd_ri_high", PW'(net_ri), PW'(1));
        peek(2'b01);
        chk("rd_stat_clear", d_out, 64'h0);

        // Writes to read-only locations are ignored
        nic_en = 1; nic_en_wr = 1; addr = 2'b11; d_in = 64'hFFFF;
        cycle();
        nic_en = 0; nic_en_wr = 0;
        peek(2'b11);
        chk("ro_write_ignored", d_out, 64'h0);

        // Async reset during the SEND cycle
        proc_write(64'h8000_0000_0000_0077);
        cycle();
        chk("pre_rst_so", PW'(net_so), PW'(1));
        #2 reset = 0;
        #1;
        model_reset();
        chk("async_rst_so", PW'(net_so), PW'(0));
        peek(2'b11);
        chk("async_rst_out_full", d_out, 64'h0);
        @(negedge clk) reset = 1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            nic_en       = ($urandom_range(0, 2) != 0);
            nic_en_wr    = $urandom_range(0, 1);
            addr         = 2'($urandom_range(0, 3));
            d_in         = {$urandom, $urandom};
            net_si       = ($urandom_range(0, 2) == 0);
            net_di       = {$urandom, $urandom};
            net_ro       = ($urandom_range(0, 3) != 0);
            net_polarity = ($urandom_range(0, 2) == 0) ? ~net_polarity : net_polarity;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
